// File: rtl/count_pulse_debouncer_pkg.sv
// Shared constants for the push-button debouncer: FSM encodings and board-default timing.
// The board top imports the same defaults, so change them here only.
package count_pulse_debouncer_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        DB_PRESS   = 2'd1,
        HELD       = 2'd2,
        DB_RELEASE = 2'd3
    } db_state_t;

    localparam int DEF_DEBOUNCE_CYCLES = 1000000;   // 10 ms at 100 MHz
    localparam int DEF_REPEAT_DELAY    = 50000000;  // 500 ms
    localparam int DEF_REPEAT_PERIOD   = 20000000;  // 200 ms
    localparam int DEF_CNT_W           = 26;

    // True when a non-negative count fits in an unsigned field of the given width.
    function automatic bit fits_width(input int value, input int width);
        return (longint'(value) >> width) == 64'd0;
    endfunction

endpackage

// File: rtl/count_pulse_debouncer_sync.sv
// Two-flop synchroniser for one asynchronous level, cleared by the async reset.
// Also used for the counter-reset button on the board.
module sync_2ff (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_d,
    output logic o_q
);

    logic r_s1;
    logic r_s2;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= i_d;
            r_s2 <= r_s1;
        end
    end

    assign o_q = r_s2;

endmodule

// File: rtl/count_pulse_debouncer.sv
// Debounces a raw push-button into single-cycle count pulses, with optional auto-repeat
// while held. pulse_out feeds the x input of the 2-4-2-1 counter directly.
module count_pulse_debouncer
    import count_pulse_debouncer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_EN       = 0,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
    parameter int CNT_W           = DEF_CNT_W
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      btn_in,
    output logic      pulse_out,
    output logic      btn_level,
    output logic      repeating,
    output db_state_t o_dbg_state
);

    if (!fits_width(DEBOUNCE_CYCLES, CNT_W) || !fits_width(REPEAT_DELAY, CNT_W) ||
        !fits_width(REPEAT_PERIOD, CNT_W)) begin : g_cnt_w_too_small
        $error("count_pulse_debouncer: CNT_W too narrow for the timing parameters");
    end

    localparam logic [CNT_W-1:0] DB_TGT   = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             w_btn_s;
    db_state_t        r_state, w_state_nx;
    logic [CNT_W-1:0] r_timer, w_timer_nx, w_timer_inc, w_rpt_last;
    logic             r_pulse, w_pulse_nx;
    logic             r_level, w_level_nx;
    logic             r_rep, w_rep_nx;

    sync_2ff u_sync (
        .i_clk   (clk),
        .i_reset (reset),
        .i_d     (btn_in),
        .o_q     (w_btn_s)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_timer <= '0;
            r_pulse <= 1'b0;
            r_level <= 1'b0;
            r_rep   <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_timer <= w_timer_nx;
            r_pulse <= w_pulse_nx;
            r_level <= w_level_nx;
            r_rep   <= w_rep_nx;
        end
    end

    // In HELD the timer counts held cycles; a repeat fires on the last cycle of each interval.
    always_comb begin
        w_state_nx  = r_state;
        w_timer_nx  = r_timer;
        w_pulse_nx  = 1'b0;
        w_level_nx  = r_level;
        w_rep_nx    = r_rep;
        w_timer_inc = (r_timer == CNT_MAX) ? r_timer : r_timer + CNT_ONE;
        w_rpt_last  = r_rep ? PER_LAST : DLY_LAST;
        unique case (r_state)
            IDLE: begin
                if (w_btn_s) begin
                    w_state_nx = DB_PRESS;
                    w_timer_nx = CNT_ONE;
                end
            end
            DB_PRESS: begin
                if (!w_btn_s) begin
                    w_state_nx = IDLE;
                    w_timer_nx = '0;
                end else if (r_timer == DB_TGT) begin
                    w_state_nx = HELD;
                    w_timer_nx = '0;
                    w_pulse_nx = 1'b1;
                    w_level_nx = 1'b1;
                end else begin
                    w_timer_nx = w_timer_inc;
                end
            end
            HELD: begin
                if (!w_btn_s) begin
                    w_state_nx = DB_RELEASE;
                    w_timer_nx = CNT_ONE;
                end else if (REPEAT_EN != 0) begin
                    if (r_timer == w_rpt_last) begin
                        w_timer_nx = '0;
                        w_pulse_nx = 1'b1;
                        w_rep_nx   = 1'b1;
                    end else begin
                        w_timer_nx = w_timer_inc;
                    end
                end
            end
            DB_RELEASE: begin
                if (w_btn_s) begin
                    w_state_nx = HELD;
                    w_timer_nx = '0;
                end else if (r_timer == DB_TGT) begin
                    w_state_nx = IDLE;
                    w_timer_nx = '0;
                    w_level_nx = 1'b0;
                    w_rep_nx   = 1'b0;
                end else begin
                    w_timer_nx = w_timer_inc;
                end
            end
            default: begin
                w_state_nx = IDLE;
                w_timer_nx = '0;
            end
        endcase
    end

    assign pulse_out   = r_pulse;
    assign btn_level   = r_level;
    assign repeating   = r_rep;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_count_pulse_debouncer.sv
// Bench for count_pulse_debouncer: one instance without and one with auto-repeat share a
// button; a run-length reference model predicts every output cycle by cycle.
module tb_count_pulse_debouncer;
    import count_pulse_debouncer_pkg::*;

    localparam int DB  = 4;
    localparam int DLY = 10;
    localparam int PER = 5;

    logic      clk = 1'b0;
    logic      reset;
    logic      btn_in;
    logic      p0, l0, r0, p1, l1, r1;
    db_state_t st0, st1;

    int n_total = 0;
    int n_pass  = 0;
    int cyc     = 0;
    bit mon_en  = 1'b0;

    count_pulse_debouncer #(.DEBOUNCE_CYCLES(DB), .REPEAT_EN(0), .REPEAT_DELAY(DLY),
                            .REPEAT_PERIOD(PER), .CNT_W(8)) dut0 (
        .clk(clk), .reset(reset), .btn_in(btn_in), .pulse_out(p0), .btn_level(l0),
        .repeating(r0), .o_dbg_state(st0));

    count_pulse_debouncer #(.DEBOUNCE_CYCLES(DB), .REPEAT_EN(1), .REPEAT_DELAY(DLY),
                            .REPEAT_PERIOD(PER), .CNT_W(8)) dut1 (
        .clk(clk), .reset(reset), .btn_in(btn_in), .pulse_out(p1), .btn_level(l1),
        .repeating(r1), .o_dbg_state(st1));

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // ---------------- reference model ----------------
    // A level is accepted once the synchronised button disagrees with it for DB+1
    // consecutive samples. While held (repeat instance only) the held-cycle count fires
    // a pulse at DLY, then every PER; any disagreement restarts that count.
    bit m_s1 = 0, m_s2 = 0;
    bit m_lvl[2] = '{0, 0};
    bit m_rep[2] = '{0, 0};
    bit e_pulse[2] = '{0, 0};
    int m_run[2] = '{0, 0};
    int m_hold[2] = '{0, 0};

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_s1 = 1'b0;
            m_s2 = 1'b0;
            for (int c = 0; c < 2; c++) begin
                m_lvl[c] = 1'b0; m_rep[c] = 1'b0; e_pulse[c] = 1'b0;
                m_run[c] = 0;    m_hold[c] = 0;
            end
        end else begin
            for (int c = 0; c < 2; c++) begin
                e_pulse[c] = 1'b0;
                if (m_s2 != m_lvl[c]) begin
                    m_run[c]++;
                    m_hold[c] = 0;
                    if (m_run[c] > DB) begin
                        m_lvl[c] = m_s2;
                        m_run[c] = 0;
                        if (m_s2) e_pulse[c] = 1'b1;
                        else      m_rep[c]   = 1'b0;
                    end
                end else if (m_run[c] != 0) begin
                    m_run[c]  = 0;
                    m_hold[c] = 0;
                end else if (m_lvl[c] && c == 1) begin
                    m_hold[c]++;
                    if (m_hold[c] == (m_rep[c] ? PER : DLY)) begin
                        e_pulse[c] = 1'b1;
                        m_rep[c]   = 1'b1;
                        m_hold[c]  = 0;
                    end
                end
            end
            m_s2 = m_s1;
            m_s1 = btn_in;
        end
    end

    // Named states follow from (accepted level, confirmation in progress).
    function automatic logic [9:0] model_vec();
        logic [9:0] v;
        for (int c = 0; c < 2; c++)
            v[c*5 +: 5] = {e_pulse[c], m_lvl[c], m_rep[c], m_lvl[c], m_run[c] != 0};
        return v;
    endfunction

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        if (mon_en) begin
            n_total++;
            if ({p1, l1, r1, st1, p0, l0, r0, st0} !== model_vec())
                $display("FAIL model_cycle cyc=%0d got=%b want=%b", cyc,
                         {p1, l1, r1, st1, p0, l0, r0, st0}, model_vec());
            else
                n_pass++;
        end
    end

    // ---------------- scenario tasks ----------------
    task automatic test_reset();
        btn_in = 1'b0;
        reset  = 1'b1;
        repeat (3) @(negedge clk);
        n_total++;
        if ({p0, l0, r0, p1, l1, r1} !== 6'b0)
            $display("FAIL reset_outputs got=%b want=000000", {p0, l0, r0, p1, l1, r1});
        else n_pass++;
        n_total++;
        if (st0 !== IDLE || st1 !== IDLE)
            $display("FAIL reset_state got=%0d/%0d want=0/0", st0, st1);
        else n_pass++;
        #2 reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_clean_press();
        int pulses = 0, first = -1, fall = -1;
        btn_in = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (p0) begin pulses++; if (first < 0) first = i; end
        end
        n_total++;
        if (pulses != 1) $display("FAIL clean_pulse_count got=%0d want=1", pulses);
        else n_pass++;
        n_total++;
        if (first - 1 < DB + 1 || first - 1 > DB + 3)
            $display("FAIL clean_latency got=%0d want=%0d..%0d", first - 1, DB + 1, DB + 3);
        else n_pass++;
        n_total++;
        if (l0 !== 1'b1) $display("FAIL clean_level_hi got=%b want=1", l0);
        else n_pass++;
        btn_in = 1'b0;
        pulses = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (p0) pulses++;
            if (!l0 && fall < 0) fall = i;
        end
        n_total++;
        if (pulses != 0) $display("FAIL release_pulse got=%0d want=0", pulses);
        else n_pass++;
        n_total++;
        if (fall - 1 < DB + 1 || fall - 1 > DB + 3)
            $display("FAIL release_latency got=%0d want=%0d..%0d", fall - 1, DB + 1, DB + 3);
        else n_pass++;
    endtask

    task automatic test_bounce();
        logic [4:0] pat = 5'b10101;
        int pulses = 0, first = -1;
        for (int k = 0; k < 5; k++) begin
            btn_in = pat[4-k];
            @(negedge clk);
            if (p0) pulses++;
        end
        for (int j = 1; j <= 14; j++) begin
            @(negedge clk);
            if (p0) begin pulses++; if (first < 0) first = j; end
        end
        n_total++;
        if (pulses != 1) $display("FAIL bounce_press_pulses got=%0d want=1", pulses);
        else n_pass++;
        n_total++;
        if (first < DB + 1 || first > DB + 3)
            $display("FAIL bounce_press_timing got=%0d want=%0d..%0d", first, DB + 1, DB + 3);
        else n_pass++;
        pat = 5'b01010;
        pulses = 0;
        for (int k = 0; k < 5; k++) begin
            btn_in = pat[4-k];
            @(negedge clk);
            if (p0) pulses++;
        end
        for (int j = 1; j <= 14; j++) begin
            @(negedge clk);
            if (p0) pulses++;
        end
        n_total++;
        if (pulses != 0 || l0 !== 1'b0)
            $display("FAIL bounce_release got=%0d/%b want=0/0", pulses, l0);
        else n_pass++;
    endtask

    task automatic test_glitch();
        int bad = 0;
        btn_in = 1'b1;
        for (int i = 0; i < 13; i++) begin
            if (i == 3) btn_in = 1'b0;
            @(negedge clk);
            if (p0 || l0 || p1 || l1) bad++;
        end
        n_total++;
        if (bad != 0) $display("FAIL glitch_no_effect got=%0d want=0", bad);
        else n_pass++;
        n_total++;
        if (st0 !== IDLE) $display("FAIL glitch_idle got=%0d want=%0d", st0, IDLE);
        else n_pass++;
    endtask

    task automatic test_repeat();
        logic [7:0] exp_q[$];
        logic [7:0] got_q[$];
        bit found = 0;
        btn_in = 1'b1;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (p1) found = 1;
        end
        n_total++;
        if (!found) $display("FAIL repeat_accept got=none want=pulse within 20 cycles");
        else n_pass++;
        for (int t = DLY; t <= 40; t += PER) exp_q.push_back(8'(t));
        for (int off = 1; off <= 40; off++) begin
            @(negedge clk);
            if (p1) got_q.push_back(8'(off));
            if (off == DLY - 1) begin
                n_total++;
                if (r1 !== 1'b0) $display("FAIL repeating_early got=%b want=0", r1);
                else n_pass++;
            end
            if (off == DLY) begin
                n_total++;
                if (r1 !== 1'b1) $display("FAIL repeating_set got=%b want=1", r1);
                else n_pass++;
            end
        end
        n_total++;
        if (got_q.size() != exp_q.size())
            $display("FAIL repeat_count got=%0d want=%0d", got_q.size(), exp_q.size());
        else n_pass++;
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            n_total++;
            if (got_q[k] !== exp_q[k])
                $display("FAIL repeat_offset%0d got=%0d want=%0d", k, got_q[k], exp_q[k]);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid_held();
        int pulses = 0, first = -1;
        n_total++;
        if (r1 !== 1'b1 || l1 !== 1'b1)
            $display("FAIL pre_reset_held got=%b%b want=11", l1, r1);
        else n_pass++;
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        n_total++;
        if ({p0, l0, r0, p1, l1, r1} !== 6'b0)
            $display("FAIL reset_mid_held got=%b want=000000", {p0, l0, r0, p1, l1, r1});
        else n_pass++;
        @(negedge clk);
        #2 reset = 1'b0;
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk);
            if (p0) begin pulses++; if (first < 0) first = i; end
        end
        n_total++;
        if (pulses != 1 || first - 1 < DB + 1 || first - 1 > DB + 3)
            $display("FAIL redebounce got=%0d@%0d want=1@%0d..%0d", pulses, first - 1, DB + 1, DB + 3);
        else n_pass++;
        btn_in = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    task automatic test_random();
        int left = 400;
        while (left > 0) begin
            int len = ($urandom_range(0, 3) == 0) ? $urandom_range(6, 20) : $urandom_range(1, 6);
            btn_in = $urandom_range(0, 1);
            for (int i = 0; i < len && left > 0; i++, left--) @(negedge clk);
        end
        btn_in = 1'b0;
        repeat (12) @(negedge clk);
        n_total++;
        if (st0 !== IDLE || st1 !== IDLE || l1 !== 1'b0)
            $display("FAIL random_settle got=%0d/%0d/%b want=0/0/0", st0, st1, l1);
        else n_pass++;
    endtask

    task automatic test_counter_chain();
        logic [3:0] tbl[10] = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100,
                                4'b1011, 4'b1100, 4'b1101, 4'b1110, 4'b1111};
        int digit = 0;
        for (int k = 0; k < 10; k++) begin
            int pulses = 0;
            logic [3:0] code;
            btn_in = 1'b1;
            for (int i = 0; i < 24; i++) begin
                if (i == 12) btn_in = 1'b0;
                @(negedge clk);
                if (p0) begin pulses++; digit = (digit + 1) % 10; end
            end
            code = (digit < 5) ? 4'(digit) : 4'(digit + 6);
            n_total++;
            if (pulses != 1) $display("FAIL chain_press%0d_pulses got=%0d want=1", k, pulses);
            else n_pass++;
            n_total++;
            if (code !== tbl[(k + 1) % 10])
                $display("FAIL chain_code%0d got=%b want=%b", k, code, tbl[(k + 1) % 10]);
            else n_pass++;
        end
    endtask

    initial begin
        reset  = 1'b1;
        btn_in = 1'b0;
        mon_en = 1'b1;
        test_reset();
        test_clean_press();
        test_bounce();
        test_glitch();
        test_repeat();
        test_reset_mid_held();
        test_random();
        test_counter_chain();
        mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
